muldiv_iter: RTL and testbench

- Parametrised, multi-cycle RV32M/RV64M-capable multiply/divide unit; successor to the single-cycle combinational M-extension path in the execute stage.
- Accepts one operation at a time via a start/busy/valid handshake and computes it with a radix-2 iterative datapath.
- Optionally uses a one-cycle registered multiplier.
- The hazard unit stalls the pipeline while busy is high.

---
 rtl/muldiv_iter_if.sv | 25 ++
 rtl/muldiv_iter.sv | 157 +++++++++++++++
 tb/tb_muldiv_iter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_iter_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit.
interface muldiv_iter_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output start, op, a, b, flush,
        input  busy, valid, result, zero
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, valid, result, zero
    );
endinterface

// File: rtl/muldiv_iter.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, optional single-cycle registered multiply.
module muldiv_iter #(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_iter_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_next;
    logic [4:0]        op_q;
    logic              sign_q;
    logic [XLEN-1:0]   mag_b_q;
    logic [2*XLEN-1:0] acc, acc_step;
    logic [CW-1:0]     count;
    logic [XLEN-1:0]   pending, result_q;
    logic              pending_zero, zero_q;

    logic              in_is_m, in_div, in_rem, a_signed, b_signed, sa, sb;
    logic              in_sign, b_zero, overflow, special, accept;
    logic [XLEN-1:0]   mag_a, mag_b, special_value, finish_value;
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;

    // Sign-correct the raw magnitude result and pick the half/part the op wants.
    function automatic logic [XLEN-1:0] finalize(input logic [4:0] fop, input logic fsign,
                                                 input logic [2*XLEN-1:0] facc);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   part;
        prod = '0;
        part = '0;
        if (fop[4]) begin
            part     = fop[3] ? facc[2*XLEN-1:XLEN] : facc[XLEN-1:0];
            finalize = fsign ? -part : part;
        end else begin
            prod     = fsign ? -facc : facc;
            finalize = (fop[3:2] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    endfunction

    // Decode the incoming request; the datapath works on magnitudes only.
    always_comb begin
        in_is_m  = bus.op[0] & ~bus.op[1];
        in_div   = bus.op[4];
        in_rem   = bus.op[4] & bus.op[3];
        a_signed = in_div ? ~bus.op[2] : (bus.op[3:2] != 2'b10);
        b_signed = in_div ? ~bus.op[2] : ~bus.op[3];
        sa       = a_signed & bus.a[XLEN-1];
        sb       = b_signed & bus.b[XLEN-1];
        mag_a    = sa ? -bus.a : bus.a;
        mag_b    = sb ? -bus.b : bus.b;
        in_sign  = in_rem ? sa : (sa ^ sb);
        b_zero   = (bus.b == '0);
        overflow = in_div & ~bus.op[2] & (bus.a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.b);
        special  = in_div ? (b_zero | overflow) : FAST_MUL;
        accept   = bus.start & in_is_m & ~bus.flush & ((state == IDLE) || (state == DONE));

        fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
        if (in_div) begin
            if (b_zero)
                special_value = in_rem ? bus.a : {XLEN{1'b1}};
            else
                special_value = in_rem ? '0 : bus.a;
        end else begin
            special_value = finalize(bus.op, in_sign, fast_prod);
        end
    end

    // One iteration: shift-add for multiply, restore-or-subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b_q} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        if (!op_q[4])
            acc_step = {mul_sum, acc[XLEN-1:1]};
        else if (div_diff[XLEN])
            acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        else
            acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        finish_value = finalize(op_q, sign_q, acc_step);
    end

    // Next-state and handshake outputs; a new op may be taken in the DONE cycle.
    always_comb begin
        state_next = state;
        bus.busy   = (state == RUN);
        bus.valid  = 1'b0;
        case (state)
            IDLE: begin
                if (accept)
                    state_next = special ? DONE : RUN;
            end
            RUN: begin
                if (bus.flush)
                    state_next = IDLE;
                else if (count == '0)
                    state_next = DONE;
            end
            DONE: begin
                bus.valid = ~bus.flush;
                if (accept)
                    state_next = special ? DONE : RUN;
                else
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The finished value is shown while valid and only committed if not flushed.
    assign bus.result = bus.valid ? pending : result_q;
    assign bus.zero   = bus.valid ? pending_zero : zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_q         <= '0;
            sign_q       <= 1'b0;
            mag_b_q      <= '0;
            acc          <= '0;
            count        <= '0;
            pending      <= '0;
            pending_zero <= 1'b1;
            result_q     <= '0;
            zero_q       <= 1'b1;
        end else begin
            state <= state_next;
            if ((state == DONE) && !bus.flush) begin
                result_q <= pending;
                zero_q   <= pending_zero;
            end
            if (accept) begin
                op_q    <= bus.op;
                sign_q  <= in_sign;
                mag_b_q <= mag_b;
                acc     <= {{XLEN{1'b0}}, mag_a};
                count   <= CW'(XLEN - 1);
                if (special) begin
                    pending      <= special_value;
                    pending_zero <= (special_value == '0);
                end
            end else if (state == RUN) begin
                acc   <= acc_step;
                count <= count - CW'(1);
                if (count == '0) begin
                    pending      <= finish_value;
                    pending_zero <= (finish_value == '0);
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: three instances (32-bit iterative,
// 32-bit fast multiply, 64-bit iterative) selected one at a time.
module tb_muldiv_iter;
    localparam logic [4:0] OP_MUL    = 5'b00001;
    localparam logic [4:0] OP_MULH   = 5'b00101;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01001;
    localparam logic [4:0] OP_DIV    = 5'b10001;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b11001;
    localparam logic [4:0] OP_REMU   = 5'b11101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          sel = 0;
    logic        start_v = 1'b0;
    logic [4:0]  op_v = 5'b0;
    logic [63:0] a_v = '0;
    logic [63:0] b_v = '0;
    logic        flush_v = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic        obs_busy, obs_valid, obs_zero;
    logic [63:0] obs_result;

    always #5 clk = ~clk;

    muldiv_iter_if #(.XLEN(32)) bus32 ();
    muldiv_iter_if #(.XLEN(32)) busf ();
    muldiv_iter_if #(.XLEN(64)) bus64 ();

    assign bus32.start = (sel == 0) ? start_v : 1'b0;
    assign bus32.flush = (sel == 0) ? flush_v : 1'b0;
    assign bus32.op    = op_v;
    assign bus32.a     = a_v[31:0];
    assign bus32.b     = b_v[31:0];
    assign busf.start  = (sel == 1) ? start_v : 1'b0;
    assign busf.flush  = (sel == 1) ? flush_v : 1'b0;
    assign busf.op     = op_v;
    assign busf.a      = a_v[31:0];
    assign busf.b      = b_v[31:0];
    assign bus64.start = (sel == 2) ? start_v : 1'b0;
    assign bus64.flush = (sel == 2) ? flush_v : 1'b0;
    assign bus64.op    = op_v;
    assign bus64.a     = a_v;
    assign bus64.b     = b_v;

    muldiv_iter #(.XLEN(32), .FAST_MUL(1'b0)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    muldiv_iter #(.XLEN(32), .FAST_MUL(1'b1)) dutf  (.clk(clk), .rst(rst), .bus(busf));
    muldiv_iter #(.XLEN(64), .FAST_MUL(1'b0)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    always_comb begin
        obs_busy   = bus32.busy;
        obs_valid  = bus32.valid;
        obs_zero   = bus32.zero;
        obs_result = {32'b0, bus32.result};
        if (sel == 1) begin
            obs_busy   = busf.busy;
            obs_valid  = busf.valid;
            obs_zero   = busf.zero;
            obs_result = {32'b0, busf.result};
        end else if (sel == 2) begin
            obs_busy   = bus64.busy;
            obs_valid  = bus64.valid;
            obs_zero   = bus64.zero;
            obs_result = bus64.result;
        end
    end

    // Present a request for one rising edge; returns just after that edge.
    task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        op_v    = op;
        a_v     = a;
        b_v     = b;
        start_v = 1'b1;
        @(posedge clk);
        #1;
        start_v = 1'b0;
    endtask

    // Counts falling edges until valid is seen; -1 if the budget runs out.
    task automatic wait_valid(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (obs_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_valids(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (obs_valid) n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if (obs_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_busy dut%0d got %b expected 0", s, obs_busy);
            end
            checks++;
            if (obs_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_valid dut%0d got %b expected 0", s, obs_valid);
            end
            checks++;
            if (obs_result !== 64'h0) begin
                errors++;
                $display("[TB] FAIL reset_result dut%0d got %h expected 0", s, obs_result);
            end
            checks++;
            if (obs_zero !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_zero dut%0d got %b expected 1", s, obs_zero);
            end
        end
        sel = 0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_div_signed();
        int lat;
        sel = 0;
        issue(OP_DIV, 64'hFFFF_FFF9, 64'h2);
        wait_valid(40, lat);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("[TB] FAIL div_latency got %0d expected 33", lat);
        end
        checks++;
        if (obs_result !== 64'hFFFF_FFFD) begin
            errors++;
            $display("[TB] FAIL div_result got %h expected fffffffd", obs_result);
        end
        @(negedge clk);
        checks++;
        if (obs_valid !== 1'b0 || obs_result !== 64'hFFFF_FFFD) begin
            errors++;
            $display("[TB] FAIL div_hold got valid=%b result=%h expected valid=0 result=fffffffd",
                     obs_valid, obs_result);
        end
        issue(OP_REM, 64'hFFFF_FFF9, 64'h2);
        wait_valid(40, lat);
        checks++;
        if (lat !== 33 || obs_result !== 64'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL rem_signed got lat=%0d result=%h expected lat=33 result=ffffffff",
                     lat, obs_result);
        end
    endtask

    task automatic test_special();
        int lat;
        sel = 0;
        issue(OP_DIVU, 64'h5, 64'h0);
        wait_valid(5, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("[TB] FAIL divu_by_zero_latency got %0d expected 1", lat);
        end
        checks++;
        if (obs_result !== 64'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL divu_by_zero got %h expected ffffffff", obs_result);
        end
        issue(OP_REMU, 64'h5, 64'h0);
        wait_valid(5, lat);
        checks++;
        if (lat !== 1 || obs_result !== 64'h5) begin
            errors++;
            $display("[TB] FAIL remu_by_zero got lat=%0d result=%h expected lat=1 result=5", lat, obs_result);
        end
        issue(OP_DIV, 64'h8000_0000, 64'hFFFF_FFFF);
        wait_valid(5, lat);
        checks++;
        if (lat !== 1 || obs_result !== 64'h8000_0000) begin
            errors++;
            $display("[TB] FAIL div_overflow got lat=%0d result=%h expected lat=1 result=80000000",
                     lat, obs_result);
        end
        issue(OP_REM, 64'h8000_0000, 64'hFFFF_FFFF);
        wait_valid(5, lat);
        checks++;
        if (lat !== 1 || obs_result !== 64'h0) begin
            errors++;
            $display("[TB] FAIL rem_overflow got lat=%0d result=%h expected lat=1 result=0", lat, obs_result);
        end
        checks++;
        if (obs_zero !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rem_overflow_zero got %b expected 1", obs_zero);
        end
    endtask

    task automatic test_mul();
        int          lat;
        logic [4:0]  ops  [4] = '{OP_MULH, OP_MULHSU, OP_MULHU, OP_MUL};
        logic [63:0] avec [4] = '{64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF};
        logic [63:0] bvec [4] = '{64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF};
        logic [63:0] exp  [4] = '{64'h4000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 64'h1};
        sel = 0;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], avec[i], bvec[i]);
            wait_valid(40, lat);
            checks++;
            if (lat !== 33 || obs_result !== exp[i]) begin
                errors++;
                $display("[TB] FAIL mul_case%0d got lat=%0d result=%h expected lat=33 result=%h",
                         i, lat, obs_result, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        sel = 1;
        #1;
        issue(OP_MUL, 64'd6, 64'd7);
        wait_valid(5, lat);
        checks++;
        if (lat !== 1 || obs_result !== 64'd42) begin
            errors++;
            $display("[TB] FAIL fast_mul got lat=%0d result=%h expected lat=1 result=2a", lat, obs_result);
        end
        issue(OP_DIVU, 64'd100, 64'd7);
        wait_valid(40, lat);
        checks++;
        if (lat !== 33 || obs_result !== 64'd14) begin
            errors++;
            $display("[TB] FAIL b2b_divu got lat=%0d result=%h expected lat=33 result=e", lat, obs_result);
        end
    endtask

    task automatic test_flush_done();
        int n;
        sel = 1;
        issue(OP_DIVU, 64'h5, 64'h0);
        flush_v = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_valid !== 1'b0 || obs_result !== 64'd14) begin
            errors++;
            $display("[TB] FAIL flush_done got valid=%b result=%h expected valid=0 result=e",
                     obs_valid, obs_result);
        end
        @(posedge clk);
        #1;
        flush_v = 1'b0;
        count_valids(5, n);
        checks++;
        if (n !== 0 || obs_result !== 64'd14) begin
            errors++;
            $display("[TB] FAIL flush_done_after got pulses=%0d result=%h expected pulses=0 result=e",
                     n, obs_result);
        end
    endtask

    task automatic test_flush_run();
        int n;
        sel = 0;
        #1;
        issue(OP_DIV, 64'd100, 64'd7);
        repeat (9) @(negedge clk);
        flush_v = 1'b1;
        @(posedge clk);
        #1;
        flush_v = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_run_busy got %b expected 0", obs_busy);
        end
        count_valids(40, n);
        checks++;
        if (n !== 0 || obs_result !== 64'h1) begin
            errors++;
            $display("[TB] FAIL flush_run got pulses=%0d result=%h expected pulses=0 result=1", n, obs_result);
        end
    endtask

    task automatic test_start_while_busy();
        int lat, n;
        sel = 0;
        issue(OP_DIVU, 64'd100, 64'd7);
        @(negedge clk);
        checks++;
        if (obs_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL run_busy got %b expected 1", obs_busy);
        end
        issue(OP_MUL, 64'd6, 64'd7);
        wait_valid(40, lat);
        checks++;
        if (lat !== 32 || obs_result !== 64'd14) begin
            errors++;
            $display("[TB] FAIL busy_start got lat=%0d result=%h expected lat=32 result=e", lat, obs_result);
        end
        count_valids(40, n);
        checks++;
        if (n !== 0) begin
            errors++;
            $display("[TB] FAIL busy_start_extra got pulses=%0d expected 0", n);
        end
    endtask

    task automatic test_flush_start_idle();
        int n;
        sel = 0;
        op_v    = OP_DIV;
        a_v     = 64'd9;
        b_v     = 64'd3;
        start_v = 1'b1;
        flush_v = 1'b1;
        @(posedge clk);
        #1;
        start_v = 1'b0;
        flush_v = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_start_busy got %b expected 0", obs_busy);
        end
        count_valids(40, n);
        checks++;
        if (n !== 0 || obs_result !== 64'd14) begin
            errors++;
            $display("[TB] FAIL flush_start got pulses=%0d result=%h expected pulses=0 result=e", n, obs_result);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        sel = 0;
        issue(OP_DIV, 64'd100, 64'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_busy !== 1'b0 || obs_valid !== 1'b0 || obs_result !== 64'h0 || obs_zero !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid got busy=%b valid=%b result=%h zero=%b expected 0 0 0 1",
                     obs_busy, obs_valid, obs_result, obs_zero);
        end
        count_valids(40, n);
        checks++;
        if (n !== 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_pulses got %0d expected 0", n);
        end
    endtask

    task automatic test_xlen64();
        int lat;
        sel = 2;
        #1;
        issue(OP_DIVU, 64'h8000_0000_0000_0000, 64'd3);
        wait_valid(80, lat);
        checks++;
        if (lat !== 65) begin
            errors++;
            $display("[TB] FAIL divu64_latency got %0d expected 65", lat);
        end
        checks++;
        if (obs_result !== 64'h2AAA_AAAA_AAAA_AAAA || obs_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL divu64 got result=%h zero=%b expected 2aaaaaaaaaaaaaaa zero=0",
                     obs_result, obs_zero);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_div_signed();
        test_special();
        test_mul();
        test_back_to_back();
        test_flush_done();
        test_flush_run();
        test_start_while_busy();
        test_flush_start_idle();
        test_reset_mid();
        test_xlen64();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
